prbs_pattern_checker: RTL and testbench

Receive-side checker for the byte stream produced by the team's PRBS pattern generator. The stream has two phases. First, a 32-bit seed word is sent MSB byte first, repeated n times. Then a PRBS-15 byte stream follows, seeded from the low 15 bits of that word. This block sits at the far end of the link, rebuilds the expected stream from the same seq/n configuration, and reports seed detection, PRBS lock and a saturating error count.

---
 rtl/prbs_pkg.sv | 20 ++
 rtl/prbs15_lfsr.sv | 23 ++
 rtl/prbs_pattern_checker.sv | 132 +++++++++++++
 tb/tb_prbs_pattern_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// PRBS-15 constants and helpers shared by the pattern generator and checker.
package prbs_pkg;

  localparam int unsigned PRBS_W = 15;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 15'h7ABC;

  typedef enum logic {
    ST_SEED,
    ST_PRBS
  } chk_state_t;

  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic logic [7:0] prbs_byte(input logic [PRBS_W-1:0] s);
    return {s[11:5], s[0]};
  endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// 15-bit PRBS register with load/advance controls and a byte tap.
module prbs15_lfsr
  import prbs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PRBS_W-1:0] load_val,
  input  logic              advance,
  output logic [7:0]        byte_out
);

  logic [PRBS_W-1:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lfsr <= PRBS_SEED;
    else if (load)    lfsr <= load_val;
    else if (advance) lfsr <= prbs_next(lfsr);
  end

  assign byte_out = prbs_byte(lfsr);

endmodule

// File: rtl/prbs_pattern_checker.sv
// Receive-side checker: seed-word repetition phase followed by a PRBS-15 byte stream,
// reporting seed detection, PRBS lock and a saturating mismatch count.
module prbs_pattern_checker
  import prbs_pkg::*;
#(
  parameter int unsigned ERR_W  = 16,
  parameter int unsigned LOCK_N = 8,
  parameter int unsigned LOSS_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      seq,
  input  logic [7:0]       n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             restart,
  input  logic             err_clr,
  output logic             seed_done,
  output logic             detected,
  output logic             prbs_lock,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned RUN_MAX = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  chk_state_t       state;
  logic [1:0]       idx;
  logic [7:0]       frame;
  logic             seed_ok;
  logic [RUN_W-1:0] match_run;
  logic [RUN_W-1:0] miss_run;

  logic [7:0]       prbs_exp;
  logic [7:0]       seed_exp;
  logic [7:0]       exp_byte;
  logic             take;
  logic             hit;
  logic             seed_end;
  logic             lfsr_adv;
  logic [RUN_W-1:0] match_nxt;
  logic [RUN_W-1:0] miss_nxt;

  prbs15_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_end),
    .load_val (seq[PRBS_W-1:0]),
    .advance  (lfsr_adv),
    .byte_out (prbs_exp)
  );

  always_comb begin
    take = in_valid & ~restart;
    unique case (idx)
      2'd0:    seed_exp = seq[31:24];
      2'd1:    seed_exp = seq[23:16];
      2'd2:    seed_exp = seq[15:8];
      default: seed_exp = seq[7:0];
    endcase
    exp_byte = (state == ST_PRBS) ? prbs_exp : seed_exp;
    hit      = (in_data == exp_byte);
    // n = 0 never ends the seed phase; the explicit guard stops frame wrap from matching it.
    seed_end = take && (state == ST_SEED) && (idx == 2'd3) &&
               (n != 8'd0) && ((frame + 8'd1) == n);
    lfsr_adv = take && (state == ST_PRBS);
    match_nxt = (match_run == RUN_W'(LOCK_N)) ? match_run : match_run + RUN_W'(1);
    miss_nxt  = (miss_run  == RUN_W'(LOSS_N)) ? miss_run  : miss_run  + RUN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SEED;
      idx       <= '0;
      frame     <= '0;
      seed_ok   <= 1'b1;
      match_run <= '0;
      miss_run  <= '0;
      seed_done <= 1'b0;
      detected  <= 1'b0;
      prbs_lock <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      seed_done <= 1'b0;
      mismatch  <= 1'b0;

      if (err_clr)
        err_cnt <= '0;
      else if (take && !hit && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;

      if (restart) begin
        state     <= ST_SEED;
        idx       <= '0;
        frame     <= '0;
        seed_ok   <= 1'b1;
        match_run <= '0;
        miss_run  <= '0;
        detected  <= 1'b0;
        prbs_lock <= 1'b0;
      end else if (in_valid) begin
        mismatch <= ~hit;
        unique case (state)
          ST_SEED: begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) frame <= frame + 8'd1;
            if (!hit) seed_ok <= 1'b0;
            if (seed_end) begin
              state     <= ST_PRBS;
              detected  <= seed_ok & hit;
              seed_done <= 1'b1;
            end
          end
          default: begin
            if (hit) begin
              match_run <= match_nxt;
              miss_run  <= '0;
              if (match_nxt == RUN_W'(LOCK_N)) prbs_lock <= 1'b1;
            end else begin
              miss_run  <= miss_nxt;
              match_run <= '0;
              if (miss_nxt == RUN_W'(LOSS_N)) prbs_lock <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_pattern_checker.sv
// Directed bench for prbs_pattern_checker: seed/PRBS phases, lock hysteresis, saturation, restart.
module tb_prbs_pattern_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seq = 32'hDEADBEEF;
  logic [7:0]  n   = 8'd2;
  logic        in_valid = 1'b0, restart = 1'b0, err_clr = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        seed_done, detected, prbs_lock, mismatch;
  logic [15:0] err_cnt;

  logic [7:0]  n4 = 8'd0;
  logic        in_valid4 = 1'b0, restart4 = 1'b0, err_clr4 = 1'b0;
  logic [7:0]  in_data4 = 8'h00;
  logic        seed_done4, detected4, prbs_lock4, mismatch4;
  logic [3:0]  err_cnt4;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic        mm_seen = 1'b0;
  logic        sd_seen = 1'b0;
  logic [14:0] tb_lfsr;
  logic [7:0]  sb [4];

  always #5 clk = ~clk;

  prbs_pattern_checker #(.ERR_W(16), .LOCK_N(8), .LOSS_N(4)) dut (
    .clk(clk), .rst(rst), .seq(seq), .n(n), .in_valid(in_valid), .in_data(in_data),
    .restart(restart), .err_clr(err_clr), .seed_done(seed_done), .detected(detected),
    .prbs_lock(prbs_lock), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  prbs_pattern_checker #(.ERR_W(4), .LOCK_N(8), .LOSS_N(4)) dut4 (
    .clk(clk), .rst(rst), .seq(seq), .n(n4), .in_valid(in_valid4), .in_data(in_data4),
    .restart(restart4), .err_clr(err_clr4), .seed_done(seed_done4), .detected(detected4),
    .prbs_lock(prbs_lock4), .mismatch(mismatch4), .err_cnt(err_cnt4)
  );

  function automatic logic [14:0] tb_next(input logic [14:0] s);
    logic [14:0] fb;
    fb = ((s >> 14) ^ (s >> 13)) & 15'd1;
    return (s << 1) | fb;
  endfunction

  function automatic logic [7:0] tb_byte(input logic [14:0] s);
    logic [14:0] t;
    t = (s >> 5) & 15'h7F;
    return {t[6:0], s[0]};
  endfunction

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rs, input logic ec);
    in_valid = v; in_data = b; restart = rs; err_clr = ec;
    @(negedge clk);
    in_valid = 1'b0; restart = 1'b0; err_clr = 1'b0;
    mm_seen = mm_seen | mismatch;
    sd_seen = sd_seen | seed_done;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic step4(input logic [7:0] b, input logic ec);
    in_valid4 = 1'b1; in_data4 = b; err_clr4 = ec;
    @(negedge clk);
    in_valid4 = 1'b0; err_clr4 = 1'b0;
  endtask

  task automatic send_prbs(input int unsigned cnt, input logic corrupt);
    repeat (cnt) begin
      send(tb_byte(tb_lfsr) ^ (corrupt ? 8'hFF : 8'h00));
      tb_lfsr = tb_next(tb_lfsr);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mm_seen = 1'b0;
    sd_seen = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({seed_done, detected, prbs_lock, mismatch} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {seed_done, detected, prbs_lock, mismatch}); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL reset_err: got %0d expected 0", err_cnt); else passed++;
    rst = 1'b0;
    send(8'hDE);
    send(8'h00);
    total++; if (mismatch !== 1'b1) $display("FAIL pre_rst_mismatch: got %b expected 1", mismatch); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL pre_rst_err: got %0d expected 1", err_cnt); else passed++;
    rst = 1'b1;
    #1;
    total++; if (err_cnt !== 16'd0) $display("FAIL async_rst_err: got %0d expected 0", err_cnt); else passed++;
    @(negedge clk);
    rst = 1'b0;
    send(8'hDE);
    total++; if (mismatch !== 1'b0) $display("FAIL post_rst_byte0: got %b expected 0", mismatch); else passed++;
  endtask

  task automatic test_clean();
    apply_reset();
    for (int k = 0; k < 7; k++) send(sb[k % 4]);
    total++; if (seed_done !== 1'b0) $display("FAIL clean_sd_early: got %b expected 0", seed_done); else passed++;
    send(sb[3]);
    total++; if (seed_done !== 1'b1) $display("FAIL clean_seed_done: got %b expected 1", seed_done); else passed++;
    total++; if (detected !== 1'b1) $display("FAIL clean_detected: got %b expected 1", detected); else passed++;
    tb_lfsr = 15'h3EEF;
    send_prbs(1, 1'b0);
    total++; if (seed_done !== 1'b0) $display("FAIL clean_sd_pulse: got %b expected 0", seed_done); else passed++;
    send_prbs(6, 1'b0);
    total++; if (prbs_lock !== 1'b0) $display("FAIL clean_lock_7: got %b expected 0", prbs_lock); else passed++;
    send_prbs(1, 1'b0);
    total++; if (prbs_lock !== 1'b1) $display("FAIL clean_lock_8: got %b expected 1", prbs_lock); else passed++;
    total++; if (mm_seen !== 1'b0) $display("FAIL clean_mismatch: got %b expected 0", mm_seen); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL clean_err: got %0d expected 0", err_cnt); else passed++;
  endtask

  task automatic test_seed_error();
    apply_reset();
    send(8'hDE); send(8'hAD); send(8'hBF);
    total++; if (mismatch !== 1'b1) $display("FAIL seederr_mismatch: got %b expected 1", mismatch); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL seederr_err: got %0d expected 1", err_cnt); else passed++;
    send(8'hEF);
    total++; if (mismatch !== 1'b0) $display("FAIL seederr_pulse: got %b expected 0", mismatch); else passed++;
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    total++; if (seed_done !== 1'b1) $display("FAIL seederr_sd: got %b expected 1", seed_done); else passed++;
    total++; if (detected !== 1'b0) $display("FAIL seederr_detected: got %b expected 0", detected); else passed++;
    tb_lfsr = 15'h3EEF;
    send_prbs(8, 1'b0);
    total++; if (prbs_lock !== 1'b1) $display("FAIL seederr_lock: got %b expected 1", prbs_lock); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL seederr_err_end: got %0d expected 1", err_cnt); else passed++;
  endtask

  task automatic test_hysteresis();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (err_cnt !== 16'd0) $display("FAIL hyst_clr: got %0d expected 0", err_cnt); else passed++;
    send_prbs(3, 1'b1);
    total++; if (prbs_lock !== 1'b1) $display("FAIL hyst_hold: got %b expected 1", prbs_lock); else passed++;
    total++; if (err_cnt !== 16'd3) $display("FAIL hyst_err3: got %0d expected 3", err_cnt); else passed++;
    send_prbs(1, 1'b1);
    total++; if (prbs_lock !== 1'b0) $display("FAIL hyst_drop: got %b expected 0", prbs_lock); else passed++;
    total++; if (err_cnt !== 16'd4) $display("FAIL hyst_err4: got %0d expected 4", err_cnt); else passed++;
    send_prbs(7, 1'b0);
    total++; if (prbs_lock !== 1'b0) $display("FAIL hyst_relock_7: got %b expected 0", prbs_lock); else passed++;
    send_prbs(1, 1'b0);
    total++; if (prbs_lock !== 1'b1) $display("FAIL hyst_relock_8: got %b expected 1", prbs_lock); else passed++;
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 15; k++) step4(~sb[k % 4], 1'b0);
    total++; if (err_cnt4 !== 4'd15) $display("FAIL sat_err15: got %0d expected 15", err_cnt4); else passed++;
    for (int k = 15; k < 20; k++) step4(~sb[k % 4], 1'b0);
    total++; if (err_cnt4 !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", err_cnt4); else passed++;
    total++; if (mismatch4 !== 1'b1) $display("FAIL sat_mismatch: got %b expected 1", mismatch4); else passed++;
    step4(~sb[0], 1'b1);
    total++; if (err_cnt4 !== 4'd0) $display("FAIL sat_clr_wins: got %0d expected 0", err_cnt4); else passed++;
    step4(~sb[1], 1'b0);
    total++; if (err_cnt4 !== 4'd1) $display("FAIL sat_after_clr: got %0d expected 1", err_cnt4); else passed++;
  endtask

  task automatic test_gaps_restart();
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      send(sb[k % 4]);
      if (k == 7) begin
        total++; if (seed_done !== 1'b1) $display("FAIL gap_sd: got %b expected 1", seed_done); else passed++;
        total++; if (detected !== 1'b1) $display("FAIL gap_detected: got %b expected 1", detected); else passed++;
      end
      step(1'b0, 8'h55, 1'b0, 1'b0);
    end
    total++; if (seed_done !== 1'b0) $display("FAIL gap_sd_pulse: got %b expected 0", seed_done); else passed++;
    tb_lfsr = 15'h3EEF;
    for (int i = 0; i < 8; i++) begin
      send(tb_byte(tb_lfsr));
      tb_lfsr = tb_next(tb_lfsr);
      if (i == 7) begin
        total++; if (prbs_lock !== 1'b1) $display("FAIL gap_lock: got %b expected 1", prbs_lock); else passed++;
      end
      step(1'b0, 8'h33, 1'b0, 1'b0);
      if (i == 6) begin
        total++; if (prbs_lock !== 1'b0) $display("FAIL gap_lock_7: got %b expected 0", prbs_lock); else passed++;
      end
    end
    total++; if (mm_seen !== 1'b0) $display("FAIL gap_mismatch: got %b expected 0", mm_seen); else passed++;
    step(1'b1, 8'h00, 1'b1, 1'b0);
    total++; if ({prbs_lock, detected, mismatch} !== 3'b000)
      $display("FAIL restart_flags: got %b expected 000", {prbs_lock, detected, mismatch}); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL restart_err: got %0d expected 0", err_cnt); else passed++;
    send(8'hDE);
    total++; if (mismatch !== 1'b0) $display("FAIL restart_byte0: got %b expected 0", mismatch); else passed++;
    send(8'h11);
    total++; if (mismatch !== 1'b1) $display("FAIL restart_byte1: got %b expected 1", mismatch); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL restart_err1: got %0d expected 1", err_cnt); else passed++;
  endtask

  task automatic test_n0();
    n = 8'd0;
    apply_reset();
    for (int k = 0; k < 400; k++) send(sb[k % 4]);
    total++; if (sd_seen !== 1'b0) $display("FAIL n0_seed_done: got %b expected 0", sd_seen); else passed++;
    total++; if (detected !== 1'b0) $display("FAIL n0_detected: got %b expected 0", detected); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL n0_err: got %0d expected 0", err_cnt); else passed++;
    send(8'h00);
    total++; if (err_cnt !== 16'd1) $display("FAIL n0_err_count: got %0d expected 1", err_cnt); else passed++;
  endtask

  initial begin
    sb[0] = 8'hDE; sb[1] = 8'hAD; sb[2] = 8'hBE; sb[3] = 8'hEF;
    test_reset();
    test_clean();
    test_seed_error();
    test_hysteresis();
    test_saturation();
    test_gaps_restart();
    test_n0();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
